// File: rtl/d_kes_buf_scheduler.sv
// Arbitrates two KES engines into the KES-CS buffer; one registered write per grant, o_exe_buf one cycle after the handshake.
// Backpressure: ready is only offered in IDLE with the buffer available; a page end waits for a low-then-high buffer handshake.
module d_kes_buf_scheduler #(
    parameter int GaloisFieldDegree = 12,
    parameter int ELPCoefficients   = 15
) (
    input  logic                                         i_clk,
    input  logic                                         i_RESET,
    input  logic                                         i_stop_dec,
    input  logic                                         i_kes0_valid,
    input  logic                                         i_kes1_valid,
    input  logic                                         i_kes0_fail,
    input  logic                                         i_kes1_fail,
    input  logic [3:0]                                   i_kes0_error_count,
    input  logic [3:0]                                   i_kes1_error_count,
    input  logic [GaloisFieldDegree*ELPCoefficients-1:0] i_kes0_elp,
    input  logic [GaloisFieldDegree*ELPCoefficients-1:0] i_kes1_elp,
    output logic                                         o_kes0_ready,
    output logic                                         o_kes1_ready,
    input  logic                                         i_buf_available,
    output logic                                         o_exe_buf,
    output logic                                         o_kes_fail,
    output logic                                         o_buf_sequence_end,
    output logic                                         o_chunk_number,
    output logic [3:0]                                   o_error_count,
    output logic [GaloisFieldDegree*ELPCoefficients-1:0] o_elp
);
    localparam int ElpW = GaloisFieldDegree * ELPCoefficients;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        GAP        = 3'd2,
        DRAIN_LOW  = 3'd3,
        DRAIN_HIGH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_done;
    logic              r_rr;
    logic              r_exe_buf;
    logic              r_kes_fail;
    logic              r_seq_end;
    logic              r_chunk;
    logic [3:0]        r_error_count;
    logic [ElpW-1:0]   r_elp;

    logic              w_clr;
    logic [1:0]        w_elig;
    logic              w_grant_vld;
    logic              w_grant_sel;
    logic [1:0]        w_done_set;

    assign w_clr      = i_RESET | i_stop_dec;
    assign w_elig     = {i_kes1_valid & ~r_done[1], i_kes0_valid & ~r_done[0]};
    assign w_done_set = r_done | (w_grant_sel ? 2'b10 : 2'b01);

    always_comb begin
        w_state_next = r_state;
        w_grant_vld  = 1'b0;
        w_grant_sel  = r_rr;
        case (r_state)
            IDLE: begin
                if (i_buf_available && (|w_elig) && !w_clr) begin
                    w_grant_vld  = 1'b1;
                    w_grant_sel  = w_elig[r_rr] ? r_rr : ~r_rr;
                    w_state_next = ISSUE;
                end
            end
            ISSUE:      w_state_next = r_seq_end ? DRAIN_LOW : GAP;
            GAP:        w_state_next = IDLE;
            DRAIN_LOW:  if (!i_buf_available) w_state_next = DRAIN_HIGH;
            DRAIN_HIGH: if (i_buf_available)  w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    assign o_kes0_ready = w_grant_vld & ~w_grant_sel;
    assign o_kes1_ready = w_grant_vld &  w_grant_sel;

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state       <= IDLE;
            r_done        <= 2'b00;
            r_rr          <= 1'b0;
            r_exe_buf     <= 1'b0;
            r_kes_fail    <= 1'b0;
            r_seq_end     <= 1'b0;
            r_chunk       <= 1'b0;
            r_error_count <= 4'd0;
            r_elp         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_exe_buf     <= 1'b0;
            r_kes_fail    <= 1'b0;
            r_seq_end     <= 1'b0;
            r_chunk       <= 1'b0;
            r_error_count <= 4'd0;
            r_elp         <= '0;
            if (w_grant_vld) begin
                r_exe_buf     <= 1'b1;
                r_chunk       <= w_grant_sel;
                r_kes_fail    <= w_grant_sel ? i_kes1_fail : i_kes0_fail;
                r_error_count <= w_grant_sel ? i_kes1_error_count : i_kes0_error_count;
                r_elp         <= w_grant_sel ? i_kes1_elp : i_kes0_elp;
                r_rr          <= ~w_grant_sel;
                // Both chunks written: close the page and reopen the mask immediately.
                if (&w_done_set) begin
                    r_seq_end <= 1'b1;
                    r_done    <= 2'b00;
                end else begin
                    r_done    <= w_done_set;
                end
            end
        end
    end

    assign o_exe_buf          = r_exe_buf;
    assign o_kes_fail         = r_kes_fail;
    assign o_buf_sequence_end = r_seq_end;
    assign o_chunk_number     = r_chunk;
    assign o_error_count      = r_error_count;
    assign o_elp              = r_elp;

endmodule

// File: tb/tb_d_kes_buf_scheduler.sv
// Directed vector table, a buffer drain timing sequence and random traffic checked against a cycle model.
module tb_d_kes_buf_scheduler;
    localparam int GFD = 12;
    localparam int ELPC = 15;
    localparam int W = GFD * ELPC;
    localparam int OW = W + 10;

    logic           clk = 1'b0;
    logic           rst, stop, v0, v1, f0, f1, av;
    logic [3:0]     e0, e1;
    logic [W-1:0]   l0, l1;
    logic           rdy0, rdy1, exe, kfail, seq, chunk;
    logic [3:0]     err;
    logic [W-1:0]   elp;
    logic [OW-1:0]  dut_out;

    always #5 clk = ~clk;

    d_kes_buf_scheduler #(.GaloisFieldDegree(GFD), .ELPCoefficients(ELPC)) dut (
        .i_clk(clk), .i_RESET(rst), .i_stop_dec(stop),
        .i_kes0_valid(v0), .i_kes1_valid(v1),
        .i_kes0_fail(f0), .i_kes1_fail(f1),
        .i_kes0_error_count(e0), .i_kes1_error_count(e1),
        .i_kes0_elp(l0), .i_kes1_elp(l1),
        .o_kes0_ready(rdy0), .o_kes1_ready(rdy1),
        .i_buf_available(av),
        .o_exe_buf(exe), .o_kes_fail(kfail), .o_buf_sequence_end(seq),
        .o_chunk_number(chunk), .o_error_count(err), .o_elp(elp)
    );

    assign dut_out = {rdy0, rdy1, exe, kfail, seq, chunk, err, elp};

    typedef struct {
        logic rst, stop, v0, v1, f1;
        logic [3:0] e0, e1;
        logic av;
        logic r0, r1, exe, fail, seq, ch;
        logic [3:0] err;
    } vec_t;

    vec_t tbl[24];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_i, stop_i, v0_i, v1_i, f1_i,
                                input logic [3:0] e0_i, e1_i, input logic av_i,
                                input logic r0_i, r1_i, exe_i, fail_i, seq_i, ch_i,
                                input logic [3:0] err_i);
        vec_t t;
        t.rst = rst_i; t.stop = stop_i; t.v0 = v0_i; t.v1 = v1_i; t.f1 = f1_i;
        t.e0 = e0_i; t.e1 = e1_i; t.av = av_i;
        t.r0 = r0_i; t.r1 = r1_i; t.exe = exe_i; t.fail = fail_i; t.seq = seq_i;
        t.ch = ch_i; t.err = err_i;
        return t;
    endfunction

    // Reference model: chunks written this page, priority engine, cycles
    // before the next grant may happen, and pending buffer drain phases.
    logic [1:0]    m_done = 2'b00;
    logic          m_rr = 1'b0;
    int            m_cool = 0;
    int            m_drain = 0;
    logic          m_exe = 0, m_fail = 0, m_seq = 0, m_ch = 0;
    logic [3:0]    m_err = 0;
    logic [W-1:0]  m_elp = '0;
    logic          s_rdy0 = 0;

    task automatic step(input logic rst_i, stop_i, v0_i, v1_i, f0_i, f1_i,
                        input logic [3:0] e0_i, e1_i, input logic [W-1:0] l0_i, l1_i,
                        input logic av_i, input string name);
        logic clr, el0, el1, gv, g;
        logic [OW-1:0] exp;
        rst = rst_i; stop = stop_i; v0 = v0_i; v1 = v1_i; f0 = f0_i; f1 = f1_i;
        e0 = e0_i; e1 = e1_i; l0 = l0_i; l1 = l1_i; av = av_i;
        @(negedge clk);
        clr = rst_i | stop_i;
        el0 = v0_i & ~m_done[0];
        el1 = v1_i & ~m_done[1];
        gv  = !clr && m_cool == 0 && m_drain == 0 && av_i && (el0 || el1);
        g   = m_rr ? (el1 ? 1'b1 : 1'b0) : (el0 ? 1'b0 : 1'b1);
        exp = {gv && !g, gv && g, m_exe, m_fail, m_seq, m_ch, m_err, m_elp};
        s_rdy0 = rdy0;
        check(name, dut_out, exp);
        m_exe = 0; m_fail = 0; m_seq = 0; m_ch = 0; m_err = 0; m_elp = '0;
        if (clr) begin
            m_done = 2'b00; m_rr = 0; m_cool = 0; m_drain = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_drain == 2) begin
            if (!av_i) m_drain = 1;
        end else if (m_drain == 1) begin
            if (av_i) m_drain = 0;
        end else if (gv) begin
            m_done[g] = 1'b1;
            m_rr  = ~g;
            m_exe = 1; m_ch = g;
            m_fail = g ? f1_i : f0_i;
            m_err  = g ? e1_i : e0_i;
            m_elp  = g ? l1_i : l0_i;
            if (m_done == 2'b11) begin
                m_seq = 1; m_done = 2'b00; m_cool = 1; m_drain = 2;
            end else begin
                m_cool = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_elp();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r = {r[W-33:0], 32'($urandom)};
        return r;
    endfunction

    initial begin
        logic [W-1:0] L0, L1;
        logic [OW-1:0] exp;
        logic avs;
        int first;
        L0 = rnd_elp();
        L1 = rnd_elp();
        //                 rst stp v0 v1 f1  e0    e1    av   r0 r1 exe fl sq ch err
        tbl[0]  = mk(1, 0, 0, 0, 0, 4'd3, 4'd5, 0,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 4'd3, 4'd5, 1,   1, 0, 0, 0, 0, 0, 4'd0);
        tbl[2]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd5, 1,   0, 0, 1, 0, 0, 0, 4'd3);
        tbl[3]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd5, 1,   0, 1, 0, 0, 0, 0, 4'd0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 4'd3, 4'd5, 1,   0, 0, 1, 0, 1, 1, 4'd5);
        tbl[6]  = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 0,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 0,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[10] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   1, 0, 0, 0, 0, 0, 4'd0);
        tbl[11] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 1, 0, 0, 0, 4'd3);
        tbl[12] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[13] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[14] = mk(0, 0, 1, 1, 1, 4'd3, 4'd0, 1,   0, 1, 0, 0, 0, 0, 4'd0);
        tbl[15] = mk(0, 0, 1, 0, 1, 4'd3, 4'd0, 1,   0, 0, 1, 1, 1, 1, 4'd0);
        tbl[16] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[17] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 0,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[18] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);
        tbl[19] = mk(0, 0, 1, 0, 0, 4'd3, 4'd5, 1,   1, 0, 0, 0, 0, 0, 4'd0);
        tbl[20] = mk(0, 1, 0, 0, 0, 4'd3, 4'd5, 1,   0, 0, 1, 0, 0, 0, 4'd3);
        tbl[21] = mk(0, 0, 1, 1, 0, 4'd3, 4'd5, 1,   1, 0, 0, 0, 0, 0, 4'd0);
        tbl[22] = mk(0, 0, 0, 0, 0, 4'd3, 4'd5, 1,   0, 0, 1, 0, 0, 0, 4'd3);
        tbl[23] = mk(0, 0, 0, 0, 0, 4'd3, 4'd5, 1,   0, 0, 0, 0, 0, 0, 4'd0);

        for (int i = 0; i < 24; i++) begin
            rst = tbl[i].rst; stop = tbl[i].stop; v0 = tbl[i].v0; v1 = tbl[i].v1;
            f0 = 1'b0; f1 = tbl[i].f1; e0 = tbl[i].e0; e1 = tbl[i].e1;
            l0 = L0; l1 = L1; av = tbl[i].av;
            @(negedge clk);
            exp = {tbl[i].r0, tbl[i].r1, tbl[i].exe, tbl[i].fail, tbl[i].seq, tbl[i].ch,
                   tbl[i].err, tbl[i].exe ? (tbl[i].ch ? L1 : L0) : {W{1'b0}}};
            check($sformatf("tbl[%0d]", i), dut_out, exp);
            @(posedge clk);
            #1;
        end

        // Drain timing: after page end the buffer stays high 5 cycles, low 4, then high.
        step(1, 0, 1, 1, 0, 0, 4'd1, 4'd2, L0, L1, 1, "drain_rst");
        first = -1;
        for (int c = 0; c < 20; c++) begin
            step(0, 0, 1, 1, 0, 0, 4'd1, 4'd2, L0, L1, !(c >= 10 && c <= 13),
                 $sformatf("drain[%0d]", c));
            if (c > 4 && s_rdy0 && first < 0) first = c;
        end
        check("drain_first_grant", OW'(first), OW'(15));

        avs = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) avs = ~avs;
            step($urandom_range(99) == 0, $urandom_range(59) == 0,
                 $urandom_range(3) != 0, $urandom_range(3) != 0,
                 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                 rnd_elp(), rnd_elp(), avs, $sformatf("rand[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
